// File: rtl/overlap_accumulator_seq_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// overlap_accumulator_seq_if : beat-in / result-out bus of the recombiner
// Rev 1.0
// ------------------------------------------------------------------------
interface overlap_accumulator_seq_if #(
  parameter int HW = 49
);
  localparam int PW = 2*HW - 1;
  localparam int OW = 4*HW - 1;

  logic          clr;
  logic          pp_valid;
  logic          pp_ready;
  logic [PW-1:0] pp_data;
  logic          pp_raw;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          busy;

  modport master (
    output clr, pp_valid, pp_data, pp_raw, out_ready,
    input  pp_ready, out_valid, out_data, busy
  );

  modport slave (
    input  clr, pp_valid, pp_data, pp_raw, out_ready,
    output pp_ready, out_valid, out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/overlap_accumulator_seq.sv
`default_nettype none
// ------------------------------------------------------------------------
// overlap_accumulator_seq : Karatsuba half-product XOR recombiner
// Rev 1.0
// ------------------------------------------------------------------------
module overlap_accumulator_seq #(
  parameter int HW = 49
) (
  input  logic                        clk,
  input  logic                        rst_n,
  overlap_accumulator_seq_if.slave    bus
);
  localparam int PW = 2*HW - 1;
  localparam int OW = 4*HW - 1;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_MID = 2'd1,
    S_HI  = 2'd2,
    S_OUT = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [OW-1:0] r_acc, w_acc_nxt;
  logic          r_raw, w_raw_nxt;
  logic          r_busy, w_busy_nxt;

  logic [OW-1:0] w_pp_lo, w_pp_mid, w_pp_hi;
  logic          w_beat, w_handoff;

  // Partial product placed at the three field offsets of the result.
  assign w_pp_lo  = {{(OW-PW){1'b0}}, bus.pp_data};
  assign w_pp_mid = w_pp_lo << HW;
  assign w_pp_hi  = w_pp_lo << (2*HW);

  assign w_beat    = bus.pp_valid && (r_state != S_OUT);
  assign w_handoff = bus.out_ready && (r_state == S_OUT);

  assign bus.pp_ready  = (r_state != S_OUT);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_data  = r_acc;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LO;
      r_acc   <= '0;
      r_raw   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_raw   <= w_raw_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_raw_nxt   = r_raw;
    w_busy_nxt  = r_busy;
    if (bus.clr) begin
      w_state_nxt = S_LO;
      w_acc_nxt   = '0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_LO: begin
          // Raw mode folds low into the middle field right away; high follows later.
          if (w_beat) begin
            w_acc_nxt   = bus.pp_raw ? (w_pp_lo ^ w_pp_mid) : w_pp_lo;
            w_raw_nxt   = bus.pp_raw;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_MID;
          end
        end
        S_MID: begin
          if (w_beat) begin
            w_acc_nxt   = r_acc ^ w_pp_mid;
            w_state_nxt = S_HI;
          end
        end
        S_HI: begin
          if (w_beat) begin
            w_acc_nxt   = r_acc ^ w_pp_hi ^ (r_raw ? w_pp_mid : '0);
            w_state_nxt = S_OUT;
          end
        end
        S_OUT: begin
          if (w_handoff) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_LO;
          end
        end
        default: begin
          w_state_nxt = S_LO;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_overlap_accumulator_seq.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_overlap_accumulator_seq : directed + random checks, HW=4 and HW=49
// Rev 1.0
// ------------------------------------------------------------------------
module tb_overlap_accumulator_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  overlap_accumulator_seq_if #(.HW(4))  if4 ();
  overlap_accumulator_seq_if #(.HW(49)) if49 ();

  overlap_accumulator_seq #(.HW(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  overlap_accumulator_seq #(.HW(49)) dut49 (.clk(clk), .rst_n(rst_n), .bus(if49));

  int compared   = 0;
  int mismatched = 0;

  logic [97:0]  a, b;
  logic [48:0]  a0, a1, b0, b1;
  logic [255:0] t_lo, t_mid, t_hi, t_full;
  logic [14:0]  exp4;
  logic [6:0]   r_lo, r_mid, r_hi;
  logic         r_rw;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Carry-less product straight from the definition of GF(2) polynomial multiply.
  function automatic logic [255:0] clmul(input logic [127:0] x, input logic [127:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 128; i++)
      if (y[i]) r ^= (256'(x) << i);
    return r;
  endfunction

  // Karatsuba recombination written from the field layout.
  function automatic logic [14:0] model4(input logic raw, input logic [6:0] lo,
                                          input logic [6:0] mid, input logic [6:0] hi);
    logic [14:0] m;
    m = raw ? 15'(mid ^ lo ^ hi) : 15'(mid);
    return 15'(lo) ^ (m << 4) ^ (15'(hi) << 8);
  endfunction

  task automatic feed4(input logic raw, input logic [6:0] lo, input logic [6:0] mid,
                       input logic [6:0] hi);
    if4.pp_valid = 1'b1; if4.pp_raw = raw; if4.pp_data = lo;
    step();
    chk("busy_after_lo", 256'(if4.busy), 256'(1));
    if4.pp_raw = ~raw; if4.pp_data = mid;
    step();
    chk("no_valid_before_hi", 256'(if4.out_valid), 256'(0));
    if4.pp_data = hi;
    step();
    if4.pp_valid = 1'b0;
  endtask

  task automatic run4(input string tag, input logic raw, input logic [6:0] lo,
                      input logic [6:0] mid, input logic [6:0] hi, input logic [14:0] exp);
    chk({tag, "_ready_idle"}, 256'(if4.pp_ready), 256'(1));
    chk({tag, "_busy_idle"}, 256'(if4.busy), 256'(0));
    feed4(raw, lo, mid, hi);
    chk({tag, "_valid"}, 256'(if4.out_valid), 256'(1));
    chk({tag, "_data"}, 256'(if4.out_data), 256'(exp));
    chk({tag, "_ready_out"}, 256'(if4.pp_ready), 256'(0));
    chk({tag, "_busy_out"}, 256'(if4.busy), 256'(1));
    if4.out_ready = 1'b1;
    step();
    if4.out_ready = 1'b0;
    chk({tag, "_valid_done"}, 256'(if4.out_valid), 256'(0));
    chk({tag, "_busy_done"}, 256'(if4.busy), 256'(0));
  endtask

  initial begin
    if4.clr = 0; if4.pp_valid = 0; if4.pp_data = '0; if4.pp_raw = 0; if4.out_ready = 0;
    if49.clr = 0; if49.pp_valid = 0; if49.pp_data = '0; if49.pp_raw = 0; if49.out_ready = 0;
    step(); step();
    chk("rst4_ready", 256'(if4.pp_ready), 256'(1));
    chk("rst4_valid", 256'(if4.out_valid), 256'(0));
    chk("rst4_busy", 256'(if4.busy), 256'(0));
    chk("rst4_data", 256'(if4.out_data), 256'(0));
    chk("rst49_ready", 256'(if49.pp_ready), 256'(1));
    chk("rst49_data", 256'(if49.out_data), 256'(0));
    rst_n = 1'b1;
    step();

    run4("tp1", 1'b0, 7'h01, 7'h00, 7'h01, 15'h0101);
    run4("tp2", 1'b1, 7'h01, 7'h00, 7'h01, 15'h0101);
    run4("tp3", 1'b0, 7'h7F, 7'h7F, 7'h00, 15'h078F);
    run4("tp4", 1'b1, 7'h05, 7'h05, 7'h00, 15'h0005);

    // Backpressure: beats offered during S_OUT must be ignored.
    feed4(1'b0, 7'h7F, 7'h7F, 7'h00);
    for (int i = 0; i < 5; i++) begin
      if4.pp_valid = 1'b1; if4.pp_data = 7'($urandom);
      step();
      chk("bp_data", 256'(if4.out_data), 256'(15'h078F));
      chk("bp_ready", 256'(if4.pp_ready), 256'(0));
      chk("bp_valid", 256'(if4.out_valid), 256'(1));
    end
    if4.out_ready = 1'b1; if4.pp_data = 7'h55;
    step();
    if4.out_ready = 1'b0; if4.pp_valid = 1'b0;
    chk("bp_handoff_valid", 256'(if4.out_valid), 256'(0));
    chk("bp_handoff_busy", 256'(if4.busy), 256'(0));
    run4("bp_next", 1'b0, 7'h03, 7'h11, 7'h40, model4(1'b0, 7'h03, 7'h11, 7'h40));

    // clr arriving together with the high beat wins.
    if4.pp_valid = 1'b1; if4.pp_raw = 1'b0; if4.pp_data = 7'h12;
    step();
    if4.pp_data = 7'h34;
    step();
    if4.pp_data = 7'h56; if4.clr = 1'b1;
    step();
    if4.clr = 1'b0; if4.pp_valid = 1'b0;
    chk("clr_busy", 256'(if4.busy), 256'(0));
    chk("clr_data", 256'(if4.out_data), 256'(0));
    chk("clr_ready", 256'(if4.pp_ready), 256'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr_no_valid", 256'(if4.out_valid), 256'(0));
    end

    // Asynchronous reset mid-transaction, checked before the next clock edge.
    if4.pp_valid = 1'b1; if4.pp_data = 7'h33;
    step();
    if4.pp_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 256'(if4.busy), 256'(0));
    chk("arst_data", 256'(if4.out_data), 256'(0));
    chk("arst_ready", 256'(if4.pp_ready), 256'(1));
    chk("arst_valid", 256'(if4.out_valid), 256'(0));
    step();
    rst_n = 1'b1;
    step();

    // clr in S_OUT drops the pending result even with out_ready high.
    feed4(1'b0, 7'h01, 7'h00, 7'h01);
    if4.out_ready = 1'b1; if4.clr = 1'b1;
    step();
    if4.out_ready = 1'b0; if4.clr = 1'b0;
    chk("clrout_valid", 256'(if4.out_valid), 256'(0));
    chk("clrout_data", 256'(if4.out_data), 256'(0));
    chk("clrout_busy", 256'(if4.busy), 256'(0));

    for (int i = 0; i < 20; i++) begin
      r_lo = 7'($urandom); r_mid = 7'($urandom); r_hi = 7'($urandom); r_rw = 1'($urandom);
      exp4 = model4(r_rw, r_lo, r_mid, r_hi);
      run4("rnd4", r_rw, r_lo, r_mid, r_hi, exp4);
    end

    // Full-width check against a software carry-less multiply.
    for (int i = 0; i < 1000; i++) begin
      a = 98'({$urandom, $urandom, $urandom, $urandom});
      b = 98'({$urandom, $urandom, $urandom, $urandom});
      r_rw = 1'($urandom);
      a0 = a[48:0]; a1 = a[97:49]; b0 = b[48:0]; b1 = b[97:49];
      t_lo = clmul(128'(a0), 128'(b0));
      t_hi = clmul(128'(a1), 128'(b1));
      t_mid = r_rw ? clmul(128'(a0 ^ a1), 128'(b0 ^ b1))
                   : (clmul(128'(a0), 128'(b1)) ^ clmul(128'(a1), 128'(b0)));
      t_full = clmul(128'(a), 128'(b));
      if49.pp_valid = 1'b1; if49.pp_raw = r_rw; if49.pp_data = t_lo[96:0];
      step();
      if49.pp_raw = 1'($urandom); if49.pp_data = t_mid[96:0];
      step();
      if49.pp_data = t_hi[96:0];
      step();
      if49.pp_valid = 1'b0;
      chk("hw49_valid", 256'(if49.out_valid), 256'(1));
      chk("hw49_data", 256'(if49.out_data), 256'(t_full[194:0]));
      if49.out_ready = 1'b1;
      step();
      if49.out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
